namuru_time_base: RTL and testbench
===================================

# namuru_time_base

Sample-domain time base for the Namuru correlator bank. Runs on the GPS sample clock and generates the periodic `pre_tic`/`tic` strobes (measurement epoch) and the `accum_int` strobe (accumulation dump / interrupt) from programmable dividers. It also keeps sticky status flags and epoch counters for the bus-side register file. All control inputs arrive already synchronized into the sample domain by the existing sample-domain synchronizers.

## Interface
- `TIC_W`, 24: width of the tic divider and tic epoch counter.
- `ACC_W`, 24: width of the accumulation divider.

- `clks` in 1: sample clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run request, level, pre-synchronized.
- `sw_rst` in 1: soft-restart pulse, pre-synchronized.
- `tic_divide` in TIC_W: tic period minus 1, in clks cycles.
- `accum_divide` in ACC_W: accumulation period minus 1.
- `status_read` in 1: one-cycle pulse that clears the status flags.
- `pre_tic` out 1: one-cycle strobe, one cycle before `tic`.
- `tic` out 1: one-cycle measurement-epoch strobe.
- `accum_int` out 1: one-cycle accumulation-dump strobe.
- `tic_status` out 1: sticky, set by `tic`.
- `accum_status` out 1: sticky, set by `accum_int`.
- `tic_count` out TIC_W: number of `tic` strobes since restart; wraps.
- `running` out 1: high while in RUN.

## Operation
- Two states:
  - IDLE: both dividers hold their loaded value and no strobes are issued.
  - RUN: both dividers count down.
- IDLE→RUN on the first cycle `enable`=1. That cycle loads both dividers: tic from `tic_divide`, accum from `accum_divide`.
- RUN→IDLE on any cycle `enable`=0. Strobes stop immediately. `tic_count` and the status flags are retained.
- Divider behaviour:
  - In RUN the counter decrements by 1 each cycle.
  - When the counter is 0 it reloads from the current divide input and raises a terminal pulse.
  - Divide value N therefore gives a period of N+1 cycles; N=0 pulses every cycle.
  - Changing a divide input mid-period takes effect only at the next reload.
- Tic chain:
  - The tic divider's terminal pulse drives `pre_tic`, registered.
  - `tic` is `pre_tic` delayed one cycle.
  - `tic_count` increments in the cycle `tic` is high, modulo 2^TIC_W.
- `accum_int` is the accum divider's terminal pulse, registered.
- `sw_rst` in RUN:
  - reloads both dividers;
  - clears `tic_count`, both status flags and the pending `pre_tic`→`tic` pipeline;
  - the state stays RUN.
- `sw_rst` in IDLE: same clears; the state stays IDLE.
- Status flags: set has priority over `status_read` in the same cycle. Otherwise `status_read` clears both flags.
- Priority order: `rst` > `enable`=0 > `sw_rst` > normal counting.

## Timing
- Reset values: state IDLE; all strobes 0; `tic_status`=0, `accum_status`=0; `tic_count`=0; `running`=0; dividers 0.
- `running` is registered and rises in the cycle after `enable` is first sampled high.
- Tic period after enable:
  - first `pre_tic` is N+2 cycles after the cycle `enable` was first sampled high (load cycle, N+1 decrements, output register);
  - `tic` follows one cycle later;
  - period thereafter is N+1 cycles.
- `accum_int` follows the same timing with M = `accum_divide`; it is independent of tic phase.
- `sw_rst` in RUN: the next `pre_tic` is N+2 cycles after the `sw_rst` cycle.
- A `pre_tic` in flight when `enable` drops or `sw_rst` arrives never produces `tic`.
- `tic_status` rises the cycle after `tic`. `tic_count` updates the cycle after `tic`.
- `rst` mid-period: all outputs return to reset values on the next edge; no partial strobes.

## Structure
- Shared package `namuru_pkg`:
  - defaults for `TIC_W`/`ACC_W`;
  - the IDLE/RUN state encoding;
  - the default divide constants used by the register file: tic 0.1 s, accum ~0.5 ms at the board sample rate.
- One sub-module, `namuru_divider`:
  - parameterised width, with `load`, `run`, `divide`, `terminal`;
  - instantiated twice, once for tic and once for accum.
- Top level holds the FSM, the tic pipeline, the status flags and `tic_count`.

## Test plan
- Reset, then `enable`=1 with `tic_divide`=9 and `accum_divide`=3:
  - first `pre_tic` 11 cycles after enable, `tic` at 12, then every 10 cycles;
  - `accum_int` first at 5, then every 4.
- `tic_divide`=0: `pre_tic` high every cycle in RUN and `tic` high every cycle from the next one. `tic_count` wraps to 0 after 2^TIC_W tics (use TIC_W=4: wraps after 16).
- Change `tic_divide` from 9 to 4 mid-period: the current period still ends at 10 cycles; following periods are 5.
- `status_read` in the same cycle `tic_status` would be set: the flag stays 1. `status_read` one cycle later: the flag is 0.
- `sw_rst` 3 cycles after `pre_tic`: no `tic` follows; `tic_count`=0; next `pre_tic` 11 cycles after `sw_rst` (N=9).
- Drop `enable` in the cycle `pre_tic` is high:
  - no `tic`; `running` falls;
  - `tic_count` is held;
  - re-enabling restarts with the full N+2 latency.

Source files
------------

// File: rtl/namuru_pkg.sv
// rtl/namuru_pkg.sv - shared widths, state encoding and default divide constants for the time base
package namuru_pkg;

  localparam int TIC_W_DEF = 24;
  localparam int ACC_W_DEF = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tb_state_e;

  // 16.368 MHz sample clock: 0.1 s tic, ~0.5 ms accumulation (values are period - 1)
  localparam logic [23:0] TIC_DIVIDE_DEF = 24'd1636799;
  localparam logic [23:0] ACC_DIVIDE_DEF = 24'd8183;

endpackage

// File: rtl/namuru_divider.sv
// rtl/namuru_divider.sv - programmable down-counter with registered terminal pulse (period = divide + 1)
module namuru_divider #(
  parameter int W = 24
) (
  input  logic         clks,
  input  logic         rst,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] divide,
  output logic         terminal
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         term_q, term_d;

  always_comb begin
    cnt_d  = cnt_q;
    term_d = 1'b0;
    if (load) begin
      cnt_d = divide;
    end else if (run) begin
      // divide is sampled only here, so mid-period changes wait for the reload
      if (cnt_q == '0) begin
        cnt_d  = divide;
        term_d = 1'b1;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clks) begin
    if (rst) begin
      cnt_q  <= '0;
      term_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end

  assign terminal = term_q;

endmodule

// File: rtl/namuru_time_base.sv
// rtl/namuru_time_base.sv - sample-domain tic / accumulation strobe generator with sticky status and tic counter
module namuru_time_base
  import namuru_pkg::*;
#(
  parameter int TIC_W = TIC_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clks,
  input  logic             rst,
  input  logic             enable,
  input  logic             sw_rst,
  input  logic [TIC_W-1:0] tic_divide,
  input  logic [ACC_W-1:0] accum_divide,
  input  logic             status_read,
  output logic             pre_tic,
  output logic             tic,
  output logic             accum_int,
  output logic             tic_status,
  output logic             accum_status,
  output logic [TIC_W-1:0] tic_count,
  output logic             running
);

  tb_state_e        state_q, state_d;
  logic             pre_tic_q, pre_tic_d;
  logic             tic_q, tic_d;
  logic             accum_int_q, accum_int_d;
  logic             tic_status_q, tic_status_d;
  logic             accum_status_q, accum_status_d;
  logic [TIC_W-1:0] tic_count_q, tic_count_d;

  logic div_load, div_run, clear;
  logic tic_term, acc_term;

  namuru_divider #(.W(TIC_W)) u_tic_div (
    .clks     (clks),
    .rst      (rst),
    .load     (div_load),
    .run      (div_run),
    .divide   (tic_divide),
    .terminal (tic_term)
  );

  namuru_divider #(.W(ACC_W)) u_acc_div (
    .clks     (clks),
    .rst      (rst),
    .load     (div_load),
    .run      (div_run),
    .divide   (accum_divide),
    .terminal (acc_term)
  );

  always_comb begin
    state_d  = state_q;
    div_load = 1'b0;
    div_run  = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clear = sw_rst;
        if (enable) begin
          state_d  = ST_RUN;
          div_load = 1'b1;
        end
      end
      ST_RUN: begin
        // dropping enable wins over sw_rst and keeps the count and flags
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (sw_rst) begin
          div_load = 1'b1;
          clear    = 1'b1;
        end else begin
          div_run = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    pre_tic_d   = div_run & tic_term;
    tic_d       = div_run & pre_tic_q;
    accum_int_d = div_run & acc_term;

    tic_count_d = tic_count_q;
    if (clear)      tic_count_d = '0;
    else if (tic_q) tic_count_d = tic_count_q + TIC_W'(1);

    tic_status_d = tic_status_q;
    if (clear)            tic_status_d = 1'b0;
    else if (tic_q)       tic_status_d = 1'b1;
    else if (status_read) tic_status_d = 1'b0;

    accum_status_d = accum_status_q;
    if (clear)            accum_status_d = 1'b0;
    else if (accum_int_q) accum_status_d = 1'b1;
    else if (status_read) accum_status_d = 1'b0;
  end

  always_ff @(posedge clks) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pre_tic_q      <= 1'b0;
      tic_q          <= 1'b0;
      accum_int_q    <= 1'b0;
      tic_status_q   <= 1'b0;
      accum_status_q <= 1'b0;
      tic_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      pre_tic_q      <= pre_tic_d;
      tic_q          <= tic_d;
      accum_int_q    <= accum_int_d;
      tic_status_q   <= tic_status_d;
      accum_status_q <= accum_status_d;
      tic_count_q    <= tic_count_d;
    end
  end

  assign pre_tic      = pre_tic_q;
  assign tic          = tic_q;
  assign accum_int    = accum_int_q;
  assign tic_status   = tic_status_q;
  assign accum_status = accum_status_q;
  assign tic_count    = tic_count_q;
  assign running      = (state_q == ST_RUN);

endmodule

// File: tb/tb_namuru_time_base.sv
// tb/tb_namuru_time_base.sv - directed bench for namuru_time_base (TIC_W=4 so the tic counter wraps quickly)
module tb_namuru_time_base;

  logic       clks = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       sw_rst = 1'b0;
  logic [3:0] tic_divide = 4'd0;
  logic [7:0] accum_divide = 8'd0;
  logic       status_read = 1'b0;
  logic       pre_tic, tic, accum_int, tic_status, accum_status, running;
  logic [3:0] tic_count;

  int vectors = 0;
  int errors = 0;

  namuru_time_base #(.TIC_W(4), .ACC_W(8)) dut (
    .clks         (clks),
    .rst          (rst),
    .enable       (enable),
    .sw_rst       (sw_rst),
    .tic_divide   (tic_divide),
    .accum_divide (accum_divide),
    .status_read  (status_read),
    .pre_tic      (pre_tic),
    .tic          (tic),
    .accum_int    (accum_int),
    .tic_status   (tic_status),
    .accum_status (accum_status),
    .tic_count    (tic_count),
    .running      (running)
  );

  always #5 clks = ~clks;

  task automatic step();
    @(posedge clks);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; sw_rst = 1'b0; status_read = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    do_reset();
    got = {pre_tic, tic, accum_int, tic_status, accum_status, running, tic_count};
    vectors++;
    if (got !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", got, 10'd0);
    end
  endtask

  task automatic test_basic_timing();
    logic ep, et, ea;
    do_reset();
    tic_divide = 4'd9; accum_divide = 8'd3; enable = 1'b1;
    step();
    vectors++;
    if (running !== 1'b1) begin errors++; $display("FAIL basic_running got %b exp 1", running); end
    for (int c = 1; c <= 35; c++) begin
      step();
      ep = (c >= 11) && ((c - 11) % 10 == 0);
      et = (c >= 12) && ((c - 12) % 10 == 0);
      ea = (c >= 5) && ((c - 5) % 4 == 0);
      vectors += 3;
      if (pre_tic !== ep) begin errors++; $display("FAIL basic_pre_tic c=%0d got %b exp %b", c, pre_tic, ep); end
      if (tic !== et) begin errors++; $display("FAIL basic_tic c=%0d got %b exp %b", c, tic, et); end
      if (accum_int !== ea) begin errors++; $display("FAIL basic_accum_int c=%0d got %b exp %b", c, accum_int, ea); end
    end
    vectors += 3;
    if (tic_count !== 4'd3) begin errors++; $display("FAIL basic_tic_count got %0d exp 3", tic_count); end
    if (tic_status !== 1'b1) begin errors++; $display("FAIL basic_tic_status got %b exp 1", tic_status); end
    if (accum_status !== 1'b1) begin errors++; $display("FAIL basic_accum_status got %b exp 1", accum_status); end
  endtask

  task automatic test_divide_zero_wrap();
    logic ep, et;
    logic [3:0] ec;
    do_reset();
    tic_divide = 4'd0; accum_divide = 8'd100; enable = 1'b1;
    step();
    for (int c = 1; c <= 25; c++) begin
      step();
      ep = (c >= 2);
      et = (c >= 3);
      ec = (c >= 3) ? 4'((c - 3) % 16) : 4'd0;
      vectors += 3;
      if (pre_tic !== ep) begin errors++; $display("FAIL div0_pre_tic c=%0d got %b exp %b", c, pre_tic, ep); end
      if (tic !== et) begin errors++; $display("FAIL div0_tic c=%0d got %b exp %b", c, tic, et); end
      if (tic_count !== ec) begin errors++; $display("FAIL div0_tic_count c=%0d got %0d exp %0d", c, tic_count, ec); end
    end
  endtask

  task automatic test_divide_change();
    logic ep;
    do_reset();
    tic_divide = 4'd9; accum_divide = 8'd100; enable = 1'b1;
    step();
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c == 13) tic_divide = 4'd4;
      ep = (c == 11) || (c == 21) || (c == 26) || (c == 31);
      vectors++;
      if (pre_tic !== ep) begin errors++; $display("FAIL divchg_pre_tic c=%0d got %b exp %b", c, pre_tic, ep); end
    end
  endtask

  task automatic test_status_read();
    do_reset();
    tic_divide = 4'd9; accum_divide = 8'd100; enable = 1'b1;
    step();
    for (int c = 1; c <= 12; c++) step();
    status_read = 1'b1;
    step();
    vectors++;
    if (tic_status !== 1'b1) begin errors++; $display("FAIL status_set_wins got %b exp 1", tic_status); end
    step();
    status_read = 1'b0;
    vectors += 2;
    if (tic_status !== 1'b0) begin errors++; $display("FAIL status_read_clear got %b exp 0", tic_status); end
    if (accum_status !== 1'b0) begin errors++; $display("FAIL status_accum_clear got %b exp 0", accum_status); end
  endtask

  task automatic test_sw_rst();
    logic ep, et;
    logic [3:0] ec;
    do_reset();
    tic_divide = 4'd9; accum_divide = 8'd100; enable = 1'b1;
    step();
    for (int c = 1; c <= 13; c++) step();
    vectors++;
    if (tic_count !== 4'd1) begin errors++; $display("FAIL swrst_pre_count got %0d exp 1", tic_count); end
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    vectors += 3;
    if (tic_count !== 4'd0) begin errors++; $display("FAIL swrst_count_clear got %0d exp 0", tic_count); end
    if (tic_status !== 1'b0) begin errors++; $display("FAIL swrst_status_clear got %b exp 0", tic_status); end
    if (running !== 1'b1) begin errors++; $display("FAIL swrst_running got %b exp 1", running); end
    for (int c = 1; c <= 14; c++) begin
      step();
      ep = (c == 11);
      et = (c == 12);
      ec = (c >= 13) ? 4'd1 : 4'd0;
      vectors += 3;
      if (pre_tic !== ep) begin errors++; $display("FAIL swrst_pre_tic c=%0d got %b exp %b", c, pre_tic, ep); end
      if (tic !== et) begin errors++; $display("FAIL swrst_tic c=%0d got %b exp %b", c, tic, et); end
      if (tic_count !== ec) begin errors++; $display("FAIL swrst_tic_count c=%0d got %0d exp %0d", c, tic_count, ec); end
    end
  endtask

  task automatic test_disable_in_flight();
    logic ep, et;
    do_reset();
    tic_divide = 4'd9; accum_divide = 8'd100; enable = 1'b1;
    step();
    for (int c = 1; c <= 31; c++) step();
    vectors++;
    if (pre_tic !== 1'b1) begin errors++; $display("FAIL dis_pre_tic_setup got %b exp 1", pre_tic); end
    enable = 1'b0;
    for (int c = 32; c <= 40; c++) begin
      step();
      vectors += 4;
      if (tic !== 1'b0) begin errors++; $display("FAIL dis_tic c=%0d got %b exp 0", c, tic); end
      if (running !== 1'b0) begin errors++; $display("FAIL dis_running c=%0d got %b exp 0", c, running); end
      if (tic_count !== 4'd2) begin errors++; $display("FAIL dis_tic_count c=%0d got %0d exp 2", c, tic_count); end
      if (tic_status !== 1'b1) begin errors++; $display("FAIL dis_tic_status c=%0d got %b exp 1", c, tic_status); end
    end
    enable = 1'b1;
    step();
    for (int c = 1; c <= 13; c++) begin
      step();
      ep = (c == 11);
      et = (c == 12);
      vectors += 2;
      if (pre_tic !== ep) begin errors++; $display("FAIL reen_pre_tic c=%0d got %b exp %b", c, pre_tic, ep); end
      if (tic !== et) begin errors++; $display("FAIL reen_tic c=%0d got %b exp %b", c, tic, et); end
    end
    vectors++;
    if (tic_count !== 4'd3) begin errors++; $display("FAIL reen_tic_count got %0d exp 3", tic_count); end
  endtask

  task automatic test_rst_mid_period();
    logic [9:0] got;
    do_reset();
    tic_divide = 4'd9; accum_divide = 8'd3; enable = 1'b1;
    step();
    for (int c = 1; c <= 13; c++) step();
    rst = 1'b1;
    step();
    got = {pre_tic, tic, accum_int, tic_status, accum_status, running, tic_count};
    vectors++;
    if (got !== 10'd0) begin errors++; $display("FAIL rst_mid_outputs got %b exp %b", got, 10'd0); end
    rst = 1'b0; enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_divide_zero_wrap();
    test_divide_change();
    test_status_read();
    test_sw_rst();
    test_disable_in_flight();
    test_rst_mid_period();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
